// File: rtl/cpcs_tx_disp_sel_if.sv
// Character/symbol bundle between the 8b10b lookup, the running-disparity stage and the serializer.
// CPCS_TX_DISP_INJECT_EN adds the inj_in disparity-error injection strobe.
interface cpcs_tx_disp_sel_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ENC6_W = 6;
  localparam int unsigned ENC4_W = 4;
  localparam int unsigned SYM_W  = 10;

  logic                valid_in;
  logic [DATA_W-1:0]   data_in;
  logic                k_in;
  logic [ENC6_W-1:0]   enc6_in;
  logic [ENC4_W-1:0]   enc4_in;
`ifdef CPCS_TX_DISP_INJECT_EN
  logic                inj_in;
`endif
  logic [SYM_W-1:0]    tx_data;
  logic                tx_valid;
  logic                rd_out;
  logic                kerr;

`ifdef CPCS_TX_DISP_INJECT_EN
  modport master (output valid_in, data_in, k_in, enc6_in, enc4_in, inj_in,
                  input  tx_data, tx_valid, rd_out, kerr);
  modport slave  (input  valid_in, data_in, k_in, enc6_in, enc4_in, inj_in,
                  output tx_data, tx_valid, rd_out, kerr);
`else
  modport master (output valid_in, data_in, k_in, enc6_in, enc4_in,
                  input  tx_data, tx_valid, rd_out, kerr);
  modport slave  (input  valid_in, data_in, k_in, enc6_in, enc4_in,
                  output tx_data, tx_valid, rd_out, kerr);
`endif
endinterface

// File: rtl/cpcs_tx_disp_sel.sv
// CorePCS 8b10b transmit running-disparity stage: complements RD-negative codes, selects D.x.7 alternates,
// tracks RD and flags illegal K characters. CPCS_TX_DISP_INJECT_EN adds a forced 6b disparity-error strobe.
module cpcs_tx_disp_sel #(
  parameter bit RD_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  cpcs_tx_disp_sel_if.slave bus
);
  localparam int unsigned SYM_W = 10;

  logic [4:0]       x;
  logic [2:0]       y;
  logic [2:0]       n6;
  logic [2:0]       nb4;
  logic             flip6;
  logic             flip4;
  logic             rdm;
  logic             alt7;
  logic [5:0]       out6;
  logic [3:0]       base4;
  logic [3:0]       out4;
  logic             rd_nxt;
  logic             k_legal;
  logic             kerr_nxt;

  logic [SYM_W-1:0] tx_data_q;
  logic             tx_valid_q;
  logic             rd_q;
  logic             kerr_q;

  // 6b sub-block, alternate 4b select, 4b sub-block and K legality for the presented character
  always_comb begin
    x        = bus.data_in[4:0];
    y        = bus.data_in[7:5];
    n6       = 3'($countones(bus.enc6_in));
    flip6    = rd_q & ((n6 == 3'd4) | (bus.enc6_in == 6'b111000));
`ifdef CPCS_TX_DISP_INJECT_EN
    if (bus.inj_in) flip6 = 1'b0;
`endif
    out6     = flip6 ? ~bus.enc6_in : bus.enc6_in;
    // Complement preserves non-neutrality, so RD from the emitted bits equals RD from the raw count
    rdm      = rd_q ^ (n6 != 3'd3);
    alt7     = (y == 3'd7) & (bus.k_in | (~rdm & out6[1] & out6[0]) | (rdm & ~out6[1] & ~out6[0]));
    base4    = alt7 ? 4'b0111 : bus.enc4_in;
    nb4      = 3'($countones(base4));
    flip4    = (rdm & ((nb4 == 3'd3) | (base4 == 4'b1100)))
             | (bus.k_in & (x == 5'd28) & (nb4 == 3'd2) & flip6);
    out4     = flip4 ? ~base4 : base4;
    rd_nxt   = rdm ^ (nb4 != 3'd2);
    k_legal  = (x == 5'd28)
             | ((y == 3'd7) & ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30)));
    kerr_nxt = bus.k_in & ~k_legal;
  end

  // Symbol, RD and K-error registers; everything holds while no character is offered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      kerr_q     <= 1'b0;
      rd_q       <= RD_INIT;
    end else begin
      tx_valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        tx_data_q <= {out6, out4};
        kerr_q    <= kerr_nxt;
        rd_q      <= rd_nxt;
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.rd_out   = rd_q;
  assign bus.kerr     = kerr_q;

endmodule

// File: tb/tb_cpcs_tx_disp_sel.sv
// Scoreboard bench for cpcs_tx_disp_sel: directed 8b10b code groups, a random back-to-back stream,
// idle hold and an asynchronous mid-stream reset.
module tb_cpcs_tx_disp_sel;
  typedef struct {
    logic [9:0] d;
    logic       rd;
    logic       kerr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t last;
  exp_t e;
  logic m_rd;
  logic exp_v;

  always #5 clk = ~clk;

  cpcs_tx_disp_sel_if bus();

  cpcs_tx_disp_sel #(.RD_INIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: RD is derived from popcounts of the bits actually emitted
  function automatic void model(input logic rd, input logic [7:0] d, input logic k,
                                input logic [5:0] e6, input logic [3:0] e4,
                                output exp_t r, output logic rd_n);
    logic [4:0] x;
    logic [2:0] y;
    logic       f6, f4, rdm, alt;
    logic [5:0] o6;
    logic [3:0] b4, o4;
    x    = d[4:0];
    y    = d[7:5];
    f6   = rd && ($countones(e6) == 4 || e6 == 6'b111000);
    o6   = f6 ? ~e6 : e6;
    rdm  = rd ^ ($countones(o6) != 3);
    alt  = (y == 3'd7) && (k || (!rdm && o6[1] && o6[0]) || (rdm && !o6[1] && !o6[0]));
    b4   = alt ? 4'b0111 : e4;
    f4   = (rdm && ($countones(b4) == 3 || b4 == 4'b1100))
        || (k && x == 5'd28 && $countones(b4) == 2 && f6);
    o4   = f4 ? ~b4 : b4;
    rd_n = rdm ^ ($countones(o4) != 2);
    r.d    = {o6, o4};
    r.rd   = rd_n;
    r.kerr = k && !(x == 5'd28 || (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30)));
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic k,
                       input logic [5:0] e6, input logic [3:0] e4);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.k_in     = k;
    bus.enc6_in  = e6;
    bus.enc4_in  = e4;
    exp_v        = v;
  endtask

  task automatic push(input logic [9:0] d, input logic rd, input logic kerr);
    exp_t r;
    r.d = d; r.rd = rd; r.kerr = kerr;
    sb.push_back(r);
    m_rd = rd;
  endtask

  // Advance one edge and compare the registered outputs against the scoreboard or held values
  task automatic tick(input string tag);
    exp_t r;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(bus.tx_valid), 32'(exp_v));
    if (exp_v) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 32'(1), 32'(0));
      end else begin
        r = sb.pop_front();
        check({tag, "_data"}, 32'(bus.tx_data), 32'(r.d));
        check({tag, "_rd"},   32'(bus.rd_out),  32'(r.rd));
        check({tag, "_kerr"}, 32'(bus.kerr),    32'(r.kerr));
        last = r;
      end
    end else begin
      check({tag, "_hold_data"}, 32'(bus.tx_data), 32'(last.d));
      check({tag, "_hold_rd"},   32'(bus.rd_out),  32'(last.rd));
      check({tag, "_hold_kerr"}, 32'(bus.kerr),    32'(last.kerr));
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       k;
    logic [5:0] e6;
    logic [3:0] e4;
    logic       rdn;
    reset = 1'b1;
`ifdef CPCS_TX_DISP_INJECT_EN
    bus.inj_in = 1'b0;
`endif
    drive(1'b0, 8'h00, 1'b0, 6'h00, 4'h0);
    m_rd = 1'b0;
    last.d = '0; last.rd = 1'b0; last.kerr = 1'b0;
    #12;
    check("rst_data",  32'(bus.tx_data),  32'(0));
    check("rst_valid", 32'(bus.tx_valid), 32'(0));
    check("rst_rd",    32'(bus.rd_out),   32'(0));
    check("rst_kerr",  32'(bus.kerr),     32'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed code groups (K28.5 = 0xBC, D21.5 = 0xB5, D7.0 = 0x07, D11.7 = 0xEB, D17.7 = 0xF1)
    drive(1'b1, 8'hBC, 1'b1, 6'b001111, 4'b1010); push(10'b0011111010, 1'b1, 1'b0); tick("k28_5_neg");
    drive(1'b1, 8'hBC, 1'b1, 6'b001111, 4'b1010); push(10'b1100000101, 1'b0, 1'b0); tick("k28_5_pos");
    drive(1'b1, 8'hB5, 1'b0, 6'b101010, 4'b1010); push(10'b1010101010, 1'b0, 1'b0); tick("d21_5");
    drive(1'b1, 8'h07, 1'b0, 6'b111000, 4'b1011); push(10'b1110001011, 1'b1, 1'b0); tick("d7_0");
    drive(1'b1, 8'hEB, 1'b0, 6'b110100, 4'b1110); push(10'b1101001000, 1'b0, 1'b0); tick("d11_7_pos");
    drive(1'b1, 8'hF1, 1'b0, 6'b100011, 4'b1110); push(10'b1000110111, 1'b1, 1'b0); tick("d17_7_neg");
    drive(1'b1, 8'h00, 1'b1, 6'b100111, 4'b1011); push(10'b0110001011, 1'b1, 1'b1); tick("k_illegal");

    drive(1'b0, 8'h00, 1'b0, 6'h00, 4'h0);
    for (int i = 0; i < 3; i++) tick("idle");

    // Random back-to-back stream with the reference model
    for (int i = 0; i < 40; i++) begin
      d  = 8'($urandom);
      k  = ($urandom_range(0, 3) == 0);
      e6 = 6'($urandom);
      e4 = 4'($urandom);
      drive(1'b1, d, k, e6, e4);
      model(m_rd, d, k, e6, e4, e, rdn);
      push(e.d, e.rd, e.kerr);
      tick("rand");
    end

    // Asynchronous reset between edges while a character is being offered
    drive(1'b1, 8'hB5, 1'b0, 6'b101010, 4'b1010);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_data",  32'(bus.tx_data),  32'(0));
    check("mid_rst_valid", 32'(bus.tx_valid), 32'(0));
    check("mid_rst_rd",    32'(bus.rd_out),   32'(0));
    check("mid_rst_kerr",  32'(bus.kerr),     32'(0));
    sb.delete();
    m_rd = 1'b0;
    last.d = '0; last.rd = 1'b0; last.kerr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 6'h00, 4'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 8'hBC, 1'b1, 6'b001111, 4'b1010); push(10'b0011111010, 1'b1, 1'b0); tick("post_rst_k28_5");
    drive(1'b0, 8'h00, 1'b0, 6'h00, 4'h0);
    tick("post_rst_idle");

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
